// File: rtl/simple_add_example_rd_sched_if.sv
// AXI4 read-address channel bundle for the simple_add_example read scheduler.
// master: the scheduler driving AR requests; slave: the m_axi port accepting them.
interface simple_add_example_rd_sched_if #(
  parameter int C_ADDR_WIDTH = 64
);
  logic                    arvalid;
  logic                    arready;
  logic [C_ADDR_WIDTH-1:0] araddr;
  logic [7:0]              arlen;

  modport master (
    output arvalid,
    output araddr,
    output arlen,
    input  arready
  );

  modport slave (
    input  arvalid,
    input  araddr,
    input  arlen,
    output arready
  );
endinterface

// File: rtl/simple_add_example_rd_sched.sv
// simple_add_example_rd_sched: splits one read transfer command into fixed-length
// AXI4 AR bursts (last one may be partial), limits in-flight bursts with an
// up/down counter and pulses ctrl_done once every issued burst has completed.
// Optional stall-cycle counter output is enabled by defining the macro
// SIMPLE_ADD_EXAMPLE_RD_SCHED_PERF_EN.
module simple_add_example_rd_sched #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
  output logic                         busy,
  simple_add_example_rd_sched_if.master ar,
  input  logic                         burst_done,
`ifdef SIMPLE_ADD_EXAMPLE_RD_SCHED_PERF_EN
  output logic [7:0]                   outstanding,
  output logic [31:0]                  stall_cycles
`else
  output logic [7:0]                   outstanding
`endif
);

  // Derived sizes. Beat math is done one bit wider than the size so that
  // sizes near 2^C_XFER_SIZE_WIDTH cannot overflow while rounding up.
  localparam int BYTES_PER_BEAT = C_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int BEAT_W         = C_XFER_SIZE_WIDTH + 1;
  localparam int BURST_BYTES    = C_BURST_LEN * BYTES_PER_BEAT;

  localparam logic [C_ADDR_WIDTH-1:0] BURST_STRIDE = C_ADDR_WIDTH'(BURST_BYTES);
  localparam logic [7:0]              MAX_OUT      = 8'(C_MAX_OUTSTANDING);
  localparam logic [7:0]              FULL_ARLEN   = 8'(C_BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]       BEAT_ROUND   = BEAT_W'(BYTES_PER_BEAT - 1);
  localparam logic [BEAT_W-1:0]       BURST_ROUND  = BEAT_W'(C_BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]       BURST_DIV    = BEAT_W'(C_BURST_LEN);
  localparam logic [BEAT_W-1:0]       BEAT_ONE     = BEAT_W'(1);

  // Control FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]                   state_reg;
  logic [2:0]                   state_next;
  logic [C_ADDR_WIDTH-1:0]      araddr_reg;
  logic [C_XFER_SIZE_WIDTH-1:0] size_reg;
  logic [BEAT_W-1:0]            bursts_left_reg;
  logic [BEAT_W-1:0]            last_len_reg;
  logic [7:0]                   outstanding_reg;
  logic [7:0]                   outstanding_next;

  logic [BEAT_W-1:0] total_beats;
  logic [BEAT_W-1:0] bursts_calc;
  logic [BEAT_W-1:0] beats_rem;
  logic [BEAT_W-1:0] last_len_calc;
  logic [7:0]        last_arlen;
  logic              issuing;
  logic              arvalid_int;
  logic              ar_hs;
  logic              done_dec;
  logic              start_accept;

  // Burst plan derived from the latched size; consumed only in SETUP
  always_comb begin
    total_beats   = ({1'b0, size_reg} + BEAT_ROUND) >> BEAT_SHIFT;
    bursts_calc   = (total_beats + BURST_ROUND) / BURST_DIV;
    beats_rem     = total_beats % BURST_DIV;
    last_len_calc = (beats_rem == '0) ? BURST_DIV : beats_rem;
  end

  // AR channel: valid whenever bursts remain and the in-flight limit allows.
  // Nothing that feeds these can change without a handshake, except the
  // outstanding count which can only fall, so a stalled request stays put.
  assign issuing      = (state_reg == ST_ISSUE) && (bursts_left_reg != '0);
  assign arvalid_int  = issuing && (outstanding_reg < MAX_OUT);
  assign ar_hs        = arvalid_int && ar.arready;
  assign done_dec     = burst_done && (outstanding_reg != 8'd0);
  assign start_accept = (state_reg == ST_IDLE) && ctrl_start;
  assign last_arlen   = 8'(last_len_reg - BEAT_ONE);

  assign ar.arvalid  = arvalid_int;
  assign ar.araddr   = araddr_reg;
  assign ar.arlen    = !issuing ? 8'd0 :
                       (bursts_left_reg == BEAT_ONE) ? last_arlen : FULL_ARLEN;
  assign outstanding = outstanding_reg;
  assign ctrl_done   = (state_reg == ST_DONE);
  assign busy        = (state_reg != ST_IDLE);

  // In-flight count: +1 per AR handshake, -1 per completed burst, never below 0
  always_comb begin
    outstanding_next = outstanding_reg;
    case ({ar_hs, done_dec})
      2'b10:   outstanding_next = outstanding_reg + 8'd1;
      2'b01:   outstanding_next = outstanding_reg - 8'd1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  // Next-state logic; DRAIN looks at the count being registered this cycle so
  // ctrl_done follows the final burst_done by exactly one cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (ctrl_start) state_next = ST_SETUP;
      ST_SETUP: state_next = (total_beats == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (ar_hs && (bursts_left_reg == BEAT_ONE)) state_next = ST_DRAIN;
      ST_DRAIN: if (outstanding_next == 8'd0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Command latch and burst address: offset loaded on start, stepped per handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr_reg <= '0;
      size_reg   <= '0;
    end else if (start_accept) begin
      araddr_reg <= ctrl_addr_offset;
      size_reg   <= ctrl_xfer_size_in_bytes;
    end else if (ar_hs) begin
      araddr_reg <= araddr_reg + BURST_STRIDE;
    end
  end

  // Burst plan registers: loaded in SETUP, bursts_left counts down per handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bursts_left_reg <= '0;
      last_len_reg    <= '0;
    end else if (state_reg == ST_SETUP) begin
      bursts_left_reg <= bursts_calc;
      last_len_reg    <= last_len_calc;
    end else if (ar_hs) begin
      bursts_left_reg <= bursts_left_reg - BEAT_ONE;
    end
  end

  // Outstanding burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_reg <= 8'd0;
    end else begin
      outstanding_reg <= outstanding_next;
    end
  end

`ifdef SIMPLE_ADD_EXAMPLE_RD_SCHED_PERF_EN
  logic [31:0] stall_reg;
  logic        stall_cond;

  // A stall is either AR backpressure or issue blocked by the in-flight limit
  assign stall_cond   = (arvalid_int && !ar.arready) ||
                        (issuing && (outstanding_reg == MAX_OUT));
  assign stall_cycles = stall_reg;

  // Saturating stall counter, cleared when a new command is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= 32'd0;
    end else if (start_accept) begin
      stall_reg <= 32'd0;
    end else if (stall_cond && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end
`endif

  // A stalled AR request must not change until it is accepted
  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    (ar.arvalid && !ar.arready) |=> (ar.arvalid && $stable(ar.araddr) && $stable(ar.arlen)));

  // In-flight count never exceeds the configured limit
  a_out_limit: assert property (@(posedge clk) disable iff (rst)
    outstanding_reg <= MAX_OUT);

  // Completion is a single-cycle pulse
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    ctrl_done |=> !ctrl_done);

endmodule
